ysyx_22050710_pc_reg: RTL and testbench
=======================================

// Module: ysyx_22050710_pc_reg
// PURPOSE
//   Program-counter register for the ysyx_22050710 core.
//   Holds the address of the instruction being fetched and drives it to the IFU.
//   Loads the next PC only when the IFU raises its load strobe, so the PC stays stable across multi-cycle fetches.
//   Sits inside the IFU, between next-PC selection and instruction memory.
// PARAMETERS
//   DATA_WIDTH  64            PC / address width in bits (legal values: 32 or 64)
//   RESET_PC    'h8000_0000   value of o_pc during and after reset, zero-extended to DATA_WIDTH
// PORTS
//   i_clk   in   1           clock; all state updates on the rising edge
//   i_rst   in   1           reset; one clock, reset is asynchronous and active-high
//   i_load  in   1           load strobe: capture i_in at the next rising edge
//   i_in    in   DATA_WIDTH  next-PC value
//   o_pc    out  DATA_WIDTH  current PC, driven directly from the state register
// BEHAVIOUR
//   - Reset: i_rst=1 forces pc_q=RESET_PC immediately (asynchronous), independent of the clock.
//     pc_q holds RESET_PC for as long as i_rst stays high.
//   - Priority: reset > load > hold. A load with i_rst=1 at the same edge is ignored.
//   - Load: at posedge with i_rst=0 and i_load=1, pc_q <= i_in (see ALIGN option).
//     o_pc shows the new value after that edge: 1-cycle latency from i_in to o_pc.
//   - Hold: i_load=0 keeps pc_q unchanged for any number of cycles.
//   - Reset release: the first edge after i_rst falls already honours i_load.
//   - o_pc has no combinational path from i_in or i_load.
//   - Back-to-back loads: i_load held high loads i_in on every edge.
//   - Width: i_in is taken at full DATA_WIDTH, with no sign or zero manipulation.
//     Arithmetic wrap (e.g. all-ones + 4) is the producer's concern; the register stores whatever it is given.
//   - X on i_in with i_load=0 must not corrupt pc_q.
// CONFIGURATION
//   YSYX_22050710_PC_ALIGN_EN
//     defined:   loaded value has bits [1:0] forced to 2'b00 (word alignment).
//                RESET_PC[1:0] must be 0; an elaboration-time check ($error) enforces this.
//     undefined: i_in is loaded verbatim, including its low bits.
// STRUCTURE
//   - Shared package ysyx_22050710_pkg holds:
//     - constant YSYX_22050710_RESET_PC = 64'h8000_0000
//     - typedef for the DATA_WIDTH address word
//   - The module is a single flat register: async-reset always block, load mux, optional alignment mask.
//   - No sub-module is needed.
// TESTING
//   1. i_rst=1 mid-cycle, no clock edge -> o_pc=0x8000_0000 immediately. Keep i_rst=1 with i_load=1 and i_in=0x1234 over 3 edges -> o_pc stays 0x8000_0000.
//   2. After reset release: i_load=1, i_in=0x8000_0004 for one edge -> o_pc=0x8000_0004 after that edge, not before it.
//   3. i_load=0 for 5 edges while i_in toggles -> o_pc unchanged.
//   4. i_load=1 for 3 edges with i_in=0x...08, 0x...0C, 0x...10 -> o_pc follows each value one edge later.
//   5. Assert i_rst asynchronously after loading 0x8000_0100 -> o_pc=0x8000_0000 before the next edge.
//      Release i_rst; next edge with i_load=1 and i_in=0x8000_0200 -> o_pc=0x8000_0200.
//   6. i_in=0x8000_0003, i_load=1 -> o_pc=0x8000_0000 with ALIGN_EN defined; o_pc=0x8000_0003 without it.

Source files
------------

// File: rtl/ysyx_22050710_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_22050710_pkg
//   Definitions shared across the ysyx_22050710 core.
//   - YSYX_22050710_XLEN     : native address / data width of the core
//   - YSYX_22050710_RESET_PC : boot address loaded into the PC on reset
//   - ysyx_22050710_word_t   : full-width address word
// -----------------------------------------------------------------------------
package ysyx_22050710_pkg;

    localparam int unsigned YSYX_22050710_XLEN = 64;

    typedef logic [YSYX_22050710_XLEN-1:0] ysyx_22050710_word_t;

    localparam ysyx_22050710_word_t YSYX_22050710_RESET_PC = 64'h0000_0000_8000_0000;

endpackage : ysyx_22050710_pkg

// File: rtl/ysyx_22050710_pc_reg.sv
// -----------------------------------------------------------------------------
// ysyx_22050710_pc_reg
//   Program-counter register inside the IFU. Holds the fetch address and only
//   advances when the IFU strobes i_load, so the PC stays stable across
//   multi-cycle fetches.
//
// Parameters
//   DATA_WIDTH : PC width in bits (32 or 64)
//   RESET_PC   : value held on o_pc during and after reset (truncated /
//                zero-extended to DATA_WIDTH)
//
// Ports
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   i_load : capture i_in at the next rising edge
//   i_in   : next-PC value
//   o_pc   : current PC, straight from the state register
//
// Configuration macro
//   YSYX_22050710_PC_ALIGN_EN : when defined, bits [1:0] of the loaded value
//                               are forced to zero; RESET_PC[1:0] must be 0.
// -----------------------------------------------------------------------------
module ysyx_22050710_pc_reg
    import ysyx_22050710_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = YSYX_22050710_XLEN,
    parameter ysyx_22050710_word_t RESET_PC   = YSYX_22050710_RESET_PC
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_in,
    output logic [DATA_WIDTH-1:0] o_pc
);

    localparam logic [DATA_WIDTH-1:0] RESET_VAL = RESET_PC[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("ysyx_22050710_pc_reg: DATA_WIDTH must be 32 or 64");
        end
`ifdef YSYX_22050710_PC_ALIGN_EN
        if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_align
            $error("ysyx_22050710_pc_reg: RESET_PC must be word aligned when alignment is enabled");
        end
`endif
    endgenerate

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_next;

    always_comb begin
        w_next = i_in;
`ifdef YSYX_22050710_PC_ALIGN_EN
        w_next[1:0] = 2'b00;
`endif
    end

    // Reset dominates load; with i_load low the register is never written,
    // so an unknown i_in cannot leak into the PC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_VAL;
        end else if (i_load) begin
            r_pc <= w_next;
        end
    end

    assign o_pc = r_pc;

endmodule : ysyx_22050710_pc_reg

// File: tb/tb_ysyx_22050710_pc_reg.sv
// -----------------------------------------------------------------------------
// tb_ysyx_22050710_pc_reg
//   Directed bench for the PC register. The driver pushes the expected PC into
//   a queue and raises chk_ev once the DUT has settled; a monitor process pops
//   each entry and compares it against o_pc.
// -----------------------------------------------------------------------------
module tb_ysyx_22050710_pc_reg;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] pc;

    ysyx_22050710_pc_reg #(
        .DATA_WIDTH(W),
        .RESET_PC  (64'h0000_0000_8000_0000)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_load(load),
        .i_in  (din),
        .o_pc  (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] exp;
        string        name;
    } chk_t;

    chk_t q[$];
    event chk_ev;
    int   n_total = 0;
    int   n_pass  = 0;

    // Model of what a load stores.
    function automatic logic [W-1:0] loaded(input logic [W-1:0] v);
`ifdef YSYX_22050710_PC_ALIGN_EN
        return {v[W-1:2], 2'b00};
`else
        return v;
`endif
    endfunction

    // Monitor: compare every queued expectation when the driver flags a sample.
    initial begin
        chk_t c;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                c = q.pop_front();
                n_total++;
                if (pc === c.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: o_pc=%h expected=%h", c.name, pc, c.exp);
                end
            end
        end
    end

    task automatic expect_pc(input logic [W-1:0] v, input string name);
        chk_t c;
        c.exp  = v;
        c.name = name;
        q.push_back(c);
        ->chk_ev;
        #0;
    endtask

    // Drive at the falling edge, let the rising edge happen, sample 1 ns later.
    task automatic edge_cycle(input logic l, input logic [W-1:0] v);
        @(negedge clk);
        load = l;
        din  = v;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] held;

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        din  = '0;

        // 1. asynchronous reset mid-cycle, then reset dominating load
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_pc(64'h8000_0000, "rst_async");
        for (int i = 0; i < 3; i++) begin
            edge_cycle(1'b1, 64'h1234);
            expect_pc(64'h8000_0000, "rst_over_load");
        end

        // 2. first edge after release honours load, not before the edge
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b1;
        din  = 64'h8000_0004;
        #1;
        expect_pc(64'h8000_0000, "load_before_edge");
        @(posedge clk);
        #1;
        expect_pc(64'h8000_0004, "load_after_edge");

        // 3. hold for 5 edges while i_in toggles (including unknown)
        held = 64'h8000_0004;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) edge_cycle(1'b0, 'x);
            else        edge_cycle(1'b0, {$urandom, $urandom});
            expect_pc(held, "hold");
        end

        // 4. back-to-back loads
        edge_cycle(1'b1, 64'h8000_0008);
        expect_pc(64'h8000_0008, "b2b_08");
        edge_cycle(1'b1, 64'h8000_000C);
        expect_pc(64'h8000_000C, "b2b_0C");
        edge_cycle(1'b1, 64'h8000_0010);
        expect_pc(64'h8000_0010, "b2b_10");

        // 5. async reset after a load, then reload after release
        edge_cycle(1'b1, 64'h8000_0100);
        expect_pc(64'h8000_0100, "load_100");
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_pc(64'h8000_0000, "rst_async_2");
        @(negedge clk);
        rst = 1'b0;
        edge_cycle(1'b1, 64'h8000_0200);
        expect_pc(64'h8000_0200, "reload_200");

        // 6. low bits: verbatim or aligned depending on build
        edge_cycle(1'b1, 64'h8000_0003);
        expect_pc(loaded(64'h8000_0003), "low_bits");

        // full-width value with no sign/zero manipulation
        edge_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_pc(loaded(64'hFFFF_FFFF_FFFF_FFFF), "all_ones");
        edge_cycle(1'b1, 64'h0123_4567_89AB_CDEE);
        expect_pc(loaded(64'h0123_4567_89AB_CDEE), "upper_bits");

        edge_cycle(1'b0, '0);
        expect_pc(loaded(64'h0123_4567_89AB_CDEE), "hold_final");

        #1;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL queue_drain: pending=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time=%0t limit=50000", $time);
        $fatal(1);
    end

endmodule : tb_ysyx_22050710_pc_reg
